serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial N-bit unsigned subtractor computing diff = a - b, LSB first, one bit per clock.
- Companion/inverse of the team's combinational 1-bit full adder cell; its datapath is a single 1-bit full-subtractor cell iterated over the operand width.
- Sits beside the adder blocks as the low-area arithmetic option, driven by a simple start/done handshake from a controller.

Parameters:
NUM_BITS, 8, operand and result width; legal range 2..32.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  NUM_BITS  minuend, captured on the accepting edge
b  input  NUM_BITS  subtrahend, captured on the accepting edge
busy  output  1  high while in SHIFT
done  output  1  one-cycle completion pulse
diff  output  NUM_BITS  registered result, held until the next completion
borrow_out  output  1  final borrow; 1 iff a < b (unsigned)

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset forces the following values immediately, regardless of clk:
  - state=IDLE; busy=0; done=0; diff=0; borrow_out=0.
  - Operand shift registers, internal borrow and bit counter all cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start=1, capture a and b into shift registers, clear the borrow, clear the counter, go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT (busy=1):
  - Each edge performs one full-subtract step on the operand LSBs with the current borrow.
  - d = a0 ^ b0 ^ bin; bout = (~a0 & b0) | (~(a0 ^ b0) & bin).
  - Shift d into the MSB of the working result register; shift both operands right; store bout; increment the counter.
  - On the edge performing step NUM_BITS-1: copy the working result into diff, bout into borrow_out, go to DONE.
- DONE: done=1, busy=0 for exactly one cycle, then unconditionally to IDLE.
- Latency: with start accepted at edge t0, done is high in the cycle after edge t0+NUM_BITS. Throughput is one operation per NUM_BITS+2 cycles.
- start while in SHIFT or DONE is ignored. It is not queued, and a/b changes are ignored.
- diff and borrow_out change only on the completion edge; they never show partial results.
- Wrap-around: the result is modulo 2^NUM_BITS (e.g. 0-1 gives all-ones, borrow_out=1).
- Counter width is $clog2(NUM_BITS). It must not overflow for NUM_BITS a power of two.
- Reset asserted mid-SHIFT aborts the operation. After release the block is in IDLE with diff=0, and no done pulse is generated.
- start held continuously starts a new operation every NUM_BITS+2 cycles.

Optional Feature:
- Macro: SERIAL_SUB_OVERFLOW_EN.
- Defined:
  - Adds output port overflow (1 bit), reset 0, updated on the same completion edge as diff.
  - overflow = signed two's-complement overflow of a - b, i.e. (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
  - Uses the MSBs of the captured operands, which are retained in a 2-bit side register.
- Undefined: the port and side register do not exist; all other behaviour is identical.

Decomposition:
- Package serial_sub_pkg holds:
  - typedef enum logic [1:0] state_t {IDLE, SHIFT, DONE};
  - localparam MAX_BITS = 32.
- Sub-module subtractor_1bit (inputs a, b, borrow_in; outputs diff, borrow_out; purely combinational) is instantiated once as the serial datapath cell.

Test Plan:
1. NUM_BITS=8, a=200, b=55, start one cycle -> busy for 8 cycles; done pulse at cycle 9; diff=145, borrow_out=0.
2. a=5, b=10 -> diff=251 (0xFB), borrow_out=1. Edge case 0-0: diff=0, borrow_out=0. Edge case 255-255: diff=0, borrow_out=0.
3. Start 20-3, then pulse start with a=99, b=1 during cycle 4 of SHIFT -> completes with diff=17; exactly one done pulse; second start ignored.
4. Start 100-1, assert rst in SHIFT cycle 3 -> outputs immediately 0, no done; after release, 7-2 completes normally with diff=5.
5. start held high with a=9, b=4 for 30 cycles -> done pulses every 10 cycles, diff=5 each time, busy low on DONE/IDLE cycles.
6. With SERIAL_SUB_OVERFLOW_EN: 0x80-0x01 gives diff=0x7F, overflow=1. 0x10-0x01 gives overflow=0. 0x7F-0xFF gives diff=0x80, overflow=1.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and width limit.
package serial_sub_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int MAX_BITS = 32;

endpackage

// File: rtl/subtractor_1bit.sv
// Combinational 1-bit full subtractor; the inverse of the 1-bit full adder cell.
module subtractor_1bit (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  assign diff       = a ^ b ^ borrow_in;
  assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor diff = a - b, LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVERFLOW_EN.
import serial_sub_pkg::*;

module serial_subtractor #(
  parameter int NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
  output logic                overflow,
`endif
  output logic                borrow_out
);

  localparam int CNT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_BITS - 1);

  state_t              state;
  logic [NUM_BITS-1:0] a_sr, b_sr, res;
  logic                bin;
  logic [CNT_W-1:0]    cnt;
  logic                d, bout;
  logic [NUM_BITS-1:0] res_nxt;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic [1:0]          msb_q;  // {a MSB, b MSB} of the captured operands
`endif

  subtractor_1bit u_cell (
    .a         (a_sr[0]),
    .b         (b_sr[0]),
    .borrow_in (bin),
    .diff      (d),
    .borrow_out(bout)
  );

  assign res_nxt = {d, res[NUM_BITS-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      a_sr       <= '0;
      b_sr       <= '0;
      res        <= '0;
      bin        <= 1'b0;
      cnt        <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      overflow   <= 1'b0;
      msb_q      <= 2'b00;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            res   <= '0;
            bin   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
`ifdef SERIAL_SUB_OVERFLOW_EN
            msb_q <= {a[NUM_BITS-1], b[NUM_BITS-1]};
`endif
          end
        end
        SHIFT: begin
          res  <= res_nxt;
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          bin  <= bout;
          // Hold the counter at the last step so power-of-two widths never wrap.
          if (cnt == LAST_STEP) begin
            diff       <= res_nxt;
            borrow_out <= bout;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
            overflow   <= (msb_q[1] ^ msb_q[0]) & (d ^ msb_q[1]);
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
